sd_fetch_cntl: RTL and testbench

- Storage-descriptor fetch controller that sits directly upstream of the storage-descriptor memory (sd_memory).
- Accepts a descriptor pointer from the manager's WU decode/execution logic and issues pipelined reads to sd_memory.
- Re-frames the returned entries into a ready/valid stream for the downstream consumer (memory-access controller).
- Stops fetching at the descriptor end marker, discards over-fetched entries, and flags descriptors that never terminate.

---
 rtl/sd_fetch_cntl.sv | 166 ++++++++++++++++
 tb/tb_sd_fetch_cntl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_fetch_cntl.sv
// Storage-descriptor fetch controller: issues credit-limited pipelined reads to
// sd_memory and re-frames the returned entries into a ready/valid stream.
module sd_fetch_cntl #(
    parameter int ADDR_W      = 10,
    parameter int OP_W        = 2,
    parameter int OPT_NUM     = 3,
    parameter int OPT_TYPE_W  = 8,
    parameter int OPT_VALUE_W = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int RD_LAT      = 2,
    parameter int MAX_LEN     = 16
) (
    input  logic                           clk,
    input  logic                           reset_poweron,
    input  logic                           xx__sdf__ptr_valid,
    input  logic [ADDR_W-1:0]              xx__sdf__ptr,
    output logic                           sdf__xx__ptr_ready,
    output logic                           sdf__sdm__read,
    output logic [ADDR_W-1:0]              sdf__sdm__addr,
    input  logic                           sdm__sdf__valid,
    input  logic [1:0]                     sdm__sdf__dcntl,
    input  logic [OP_W-1:0]                sdm__sdf__op,
    input  logic [OPT_NUM*OPT_TYPE_W-1:0]  sdm__sdf__option_type,
    input  logic [OPT_NUM*OPT_VALUE_W-1:0] sdm__sdf__option_value,
    output logic                           sdf__xx__valid,
    output logic [1:0]                     sdf__xx__cntl,
    output logic [OP_W-1:0]                sdf__xx__op,
    output logic [OPT_NUM*OPT_TYPE_W-1:0]  sdf__xx__option_type,
    output logic [OPT_NUM*OPT_VALUE_W-1:0] sdf__xx__option_value,
    input  logic                           xx__sdf__ready,
    output logic                           sdf__xx__error
);

    localparam int ENT_W = 2 + OP_W + OPT_NUM*OPT_TYPE_W + OPT_NUM*OPT_VALUE_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rdAddr_q, rdAddr_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    returned_q, returned_d;
    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    fifoCount_q, fifoCount_d;
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic                read_q, read_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                error_q, error_d;
    logic [ENT_W-1:0]    fifoMem [FIFO_DEPTH];

    logic                issue;
    logic                retire;
    logic                push;
    logic                pop;
    logic                creditOk;
    logic [1:0]          pushCntl;
    logic [ENT_W-1:0]    pushEntry;

    // Credit covers both outstanding reads and buffered entries, so a push can never overflow.
    always_comb begin
        state_d     = state_q;
        rdAddr_d    = rdAddr_q;
        issued_d    = issued_q;
        returned_d  = returned_q;
        addr_d      = addr_q;
        read_d      = 1'b0;
        error_d     = 1'b0;
        issue       = 1'b0;
        push        = 1'b0;
        pushCntl    = sdm__sdf__dcntl;
        retire      = sdm__sdf__valid && (inflight_q != '0);
        creditOk    = ({1'b0, inflight_q} + {1'b0, fifoCount_q}) < (CNT_W+1)'(FIFO_DEPTH);

        case (state_q)
            IDLE: begin
                if (xx__sdf__ptr_valid) begin
                    rdAddr_d   = xx__sdf__ptr;
                    issued_d   = '0;
                    returned_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                issue = creditOk && (issued_q < LEN_W'(MAX_LEN));
                if (sdm__sdf__valid) begin
                    push       = 1'b1;
                    returned_d = returned_q + 1'b1;
                    if (sdm__sdf__dcntl[1]) begin
                        state_d = DRAIN;
                    end else if (returned_q == LEN_W'(MAX_LEN - 1)) begin
                        pushCntl = 2'b10;
                        error_d  = 1'b1;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((inflight_q == '0) || ((inflight_q == CNT_W'(1)) && retire)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            read_d   = 1'b1;
            addr_d   = rdAddr_q;
            rdAddr_d = rdAddr_q + 1'b1;
            issued_d = issued_q + 1'b1;
        end

        inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(retire);
        pop         = (fifoCount_q != '0) && xx__sdf__ready;
        fifoCount_d = fifoCount_q + CNT_W'(push) - CNT_W'(pop);
        wrPtr_d     = wrPtr_q + PTR_W'(push);
        rdPtr_d     = rdPtr_q + PTR_W'(pop);
        pushEntry   = {pushCntl, sdm__sdf__op, sdm__sdf__option_type, sdm__sdf__option_value};
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q     <= IDLE;
            rdAddr_q    <= '0;
            issued_q    <= '0;
            returned_q  <= '0;
            inflight_q  <= '0;
            fifoCount_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            read_q      <= 1'b0;
            addr_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdAddr_q    <= rdAddr_d;
            issued_q    <= issued_d;
            returned_q  <= returned_d;
            inflight_q  <= inflight_d;
            fifoCount_q <= fifoCount_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            error_q     <= error_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push && !reset_poweron) begin
            fifoMem[wrPtr_q] <= pushEntry;
        end
    end

    assign sdf__xx__ptr_ready = (state_q == IDLE);
    assign sdf__sdm__read     = read_q;
    assign sdf__sdm__addr     = addr_q;
    assign sdf__xx__error     = error_q;
    assign sdf__xx__valid     = (fifoCount_q != '0);
    assign {sdf__xx__cntl, sdf__xx__op, sdf__xx__option_type, sdf__xx__option_value} =
        sdf__xx__valid ? fifoMem[rdPtr_q] : '0;

endmodule

// File: tb/tb_sd_fetch_cntl.sv
// Scoreboard bench for sd_fetch_cntl: a two-cycle sd_memory model feeds the DUT,
// directed descriptors push expected entries, and a monitor compares every pop.
module tb_sd_fetch_cntl;

    logic         clk = 1'b0;
    logic         reset_poweron;
    logic         xx__sdf__ptr_valid;
    logic [9:0]   xx__sdf__ptr;
    logic         sdf__xx__ptr_ready;
    logic         sdf__sdm__read;
    logic [9:0]   sdf__sdm__addr;
    logic         sdm__sdf__valid;
    logic [1:0]   sdm__sdf__dcntl;
    logic [1:0]   sdm__sdf__op;
    logic [23:0]  sdm__sdf__option_type;
    logic [71:0]  sdm__sdf__option_value;
    logic         sdf__xx__valid;
    logic [1:0]   sdf__xx__cntl;
    logic [1:0]   sdf__xx__op;
    logic [23:0]  sdf__xx__option_type;
    logic [71:0]  sdf__xx__option_value;
    logic         xx__sdf__ready;
    logic         sdf__xx__error;

    sd_fetch_cntl dut (
        .clk                    (clk),
        .reset_poweron          (reset_poweron),
        .xx__sdf__ptr_valid     (xx__sdf__ptr_valid),
        .xx__sdf__ptr           (xx__sdf__ptr),
        .sdf__xx__ptr_ready     (sdf__xx__ptr_ready),
        .sdf__sdm__read         (sdf__sdm__read),
        .sdf__sdm__addr         (sdf__sdm__addr),
        .sdm__sdf__valid        (sdm__sdf__valid),
        .sdm__sdf__dcntl        (sdm__sdf__dcntl),
        .sdm__sdf__op           (sdm__sdf__op),
        .sdm__sdf__option_type  (sdm__sdf__option_type),
        .sdm__sdf__option_value (sdm__sdf__option_value),
        .sdf__xx__valid         (sdf__xx__valid),
        .sdf__xx__cntl          (sdf__xx__cntl),
        .sdf__xx__op            (sdf__xx__op),
        .sdf__xx__option_type   (sdf__xx__option_type),
        .sdf__xx__option_value  (sdf__xx__option_value),
        .xx__sdf__ready         (xx__sdf__ready),
        .sdf__xx__error         (sdf__xx__error)
    );

    always #5 clk = ~clk;

    logic [1:0]  memCntl  [1024];
    logic [1:0]  memOp    [1024];
    logic [23:0] memType  [1024];
    logic [71:0] memValue [1024];

    // Two-stage read pipeline: a read sampled at edge k returns valid at edge k+2.
    logic       pipeVld1 = 1'b0, pipeVld2 = 1'b0;
    logic [9:0] pipeAddr1 = '0, pipeAddr2 = '0;
    always @(posedge clk) begin
        pipeVld1  <= sdf__sdm__read;
        pipeAddr1 <= sdf__sdm__addr;
        pipeVld2  <= pipeVld1;
        pipeAddr2 <= pipeAddr1;
    end
    assign sdm__sdf__valid        = pipeVld2;
    assign sdm__sdf__dcntl        = memCntl[pipeAddr2];
    assign sdm__sdf__op           = memOp[pipeAddr2];
    assign sdm__sdf__option_type  = memType[pipeAddr2];
    assign sdm__sdf__option_value = memValue[pipeAddr2];

    logic [99:0] expQ [$];
    logic [9:0]  readQ [$];
    int vectors     = 0;
    int miscompares = 0;
    int readCount   = 0;
    int errCycles   = 0;
    int outCount    = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_poweron) begin
            if (sdf__sdm__read) begin
                readQ.push_back(sdf__sdm__addr);
                readCount++;
            end
            if (sdf__xx__error) errCycles++;
            if (sdf__xx__valid && xx__sdf__ready) begin
                outCount++;
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_entry: got cntl=%0d op=%0d, expected no output",
                             sdf__xx__cntl, sdf__xx__op);
                end else begin
                    checkOutput("entry",
                                {28'd0, sdf__xx__cntl, sdf__xx__op, sdf__xx__option_type, sdf__xx__option_value},
                                {28'd0, expQ.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill one memory entry with an address-derived payload; optionally expect it downstream.
    task automatic loadEntry(input logic [9:0] addr, input logic [1:0] cntl, input logic [1:0] op,
                             input bit expect_out, input logic [1:0] expCntl);
        memCntl[addr]  = cntl;
        memOp[addr]    = op;
        memType[addr]  = {addr[7:0] + 8'd3, addr[7:0] ^ 8'hA5, addr[7:0]};
        memValue[addr] = {14'h2A5, addr, 14'h1234, addr, 14'h0F0F, ~addr};
        if (expect_out)
            expQ.push_back({expCntl, op, memType[addr], memValue[addr]});
    endtask

    task automatic applyStimulus(input logic [9:0] ptr);
        checkOutput("ptr_ready_before_issue", {127'd0, sdf__xx__ptr_ready}, 128'd1);
        xx__sdf__ptr_valid = 1'b1;
        xx__sdf__ptr       = ptr;
        tick();
        xx__sdf__ptr_valid = 1'b0;
        xx__sdf__ptr       = '0;
    endtask

    task automatic waitDone(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sdf__xx__ptr_ready && expQ.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(name, {127'd0, ok}, 128'd1);
        repeat (6) tick();
    endtask

    logic [1:0] cntl4 [4];
    logic [1:0] cntl6 [6];

    initial begin
        reset_poweron      = 1'b1;
        xx__sdf__ptr_valid = 1'b0;
        xx__sdf__ptr       = '0;
        xx__sdf__ready     = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            memCntl[a] = 2'b00; memOp[a] = 2'd0; memType[a] = '0; memValue[a] = '0;
        end
        repeat (3) tick();
        reset_poweron = 1'b0;
        #3;
        checkOutput("reset_ptr_ready", {127'd0, sdf__xx__ptr_ready}, 128'd1);
        checkOutput("reset_read",      {127'd0, sdf__sdm__read}, 128'd0);
        checkOutput("reset_addr",      {118'd0, sdf__sdm__addr}, 128'd0);
        checkOutput("reset_valid",     {127'd0, sdf__xx__valid}, 128'd0);
        checkOutput("reset_data",      {28'd0, sdf__xx__cntl, sdf__xx__op, sdf__xx__option_type, sdf__xx__option_value}, 128'd0);
        checkOutput("reset_error",     {127'd0, sdf__xx__error}, 128'd0);
        tick();

        $display("[TB] single-entry descriptor");
        loadEntry(10'h010, 2'b11, 2'd1, 1'b1, 2'b11);
        for (int i = 1; i < 5; i++) loadEntry(10'h010 + 10'(i), 2'b00, 2'd2, 1'b0, 2'b00);
        outCount = 0; errCycles = 0;
        applyStimulus(10'h010);
        waitDone("single_done", 60);
        checkOutput("single_out_count", 128'(outCount), 128'd1);
        checkOutput("single_error", 128'(errCycles), 128'd0);

        $display("[TB] four-entry descriptor");
        cntl4[0] = 2'b01; cntl4[1] = 2'b00; cntl4[2] = 2'b00; cntl4[3] = 2'b10;
        for (int i = 0; i < 4; i++) loadEntry(10'h020 + 10'(i), cntl4[i], 2'(i), 1'b1, cntl4[i]);
        for (int i = 4; i < 8; i++) loadEntry(10'h020 + 10'(i), 2'b00, 2'd3, 1'b0, 2'b00);
        outCount = 0; errCycles = 0;
        applyStimulus(10'h020);
        waitDone("four_done", 80);
        checkOutput("four_out_count", 128'(outCount), 128'd4);
        checkOutput("four_error", 128'(errCycles), 128'd0);

        $display("[TB] backpressure");
        cntl6[0] = 2'b01; cntl6[1] = 2'b00; cntl6[2] = 2'b00;
        cntl6[3] = 2'b00; cntl6[4] = 2'b00; cntl6[5] = 2'b10;
        for (int i = 0; i < 6; i++) loadEntry(10'h040 + 10'(i), cntl6[i], 2'(3 - (i % 4)), 1'b1, cntl6[i]);
        outCount = 0; readCount = 0;
        xx__sdf__ready = 1'b0;
        applyStimulus(10'h040);
        repeat (20) tick();
        checkOutput("bp_reads_held", 128'(readCount), 128'd4);
        checkOutput("bp_valid_held", {127'd0, sdf__xx__valid}, 128'd1);
        checkOutput("bp_no_output", 128'(outCount), 128'd0);
        xx__sdf__ready = 1'b1;
        waitDone("bp_done", 80);
        checkOutput("bp_out_count", 128'(outCount), 128'd6);

        $display("[TB] address wrap");
        loadEntry(10'h3FE, 2'b01, 2'd1, 1'b1, 2'b01);
        loadEntry(10'h3FF, 2'b00, 2'd2, 1'b1, 2'b00);
        loadEntry(10'h000, 2'b10, 2'd3, 1'b1, 2'b10);
        loadEntry(10'h001, 2'b00, 2'd0, 1'b0, 2'b00);
        readQ.delete(); outCount = 0;
        applyStimulus(10'h3FE);
        waitDone("wrap_done", 60);
        checkOutput("wrap_read_count_min", 128'(readQ.size() >= 3), 128'd1);
        if (readQ.size() >= 3) begin
            checkOutput("wrap_addr0", {118'd0, readQ[0]}, 128'h3FE);
            checkOutput("wrap_addr1", {118'd0, readQ[1]}, 128'h3FF);
            checkOutput("wrap_addr2", {118'd0, readQ[2]}, 128'h000);
        end
        checkOutput("wrap_out_count", 128'(outCount), 128'd3);

        $display("[TB] unterminated descriptor");
        for (int i = 0; i < 20; i++)
            loadEntry(10'h100 + 10'(i), 2'b00, 2'(i), (i < 16), (i == 15) ? 2'b10 : 2'b00);
        outCount = 0; readCount = 0; errCycles = 0;
        applyStimulus(10'h100);
        waitDone("noterm_done", 200);
        checkOutput("noterm_out_count", 128'(outCount), 128'd16);
        checkOutput("noterm_reads", 128'(readCount), 128'd16);
        checkOutput("noterm_error_cycles", 128'(errCycles), 128'd1);
        checkOutput("noterm_ptr_ready", {127'd0, sdf__xx__ptr_ready}, 128'd1);

        $display("[TB] reset during fetch");
        for (int i = 0; i < 4; i++) loadEntry(10'h200 + 10'(i), cntl4[i], 2'd1, 1'b0, 2'b00);
        readCount = 0; outCount = 0;
        applyStimulus(10'h200);
        for (int i = 0; i < 10 && readCount < 2; i++) tick();
        checkOutput("rst_reads_seen", 128'(readCount >= 2), 128'd1);
        reset_poweron = 1'b1;
        tick();
        reset_poweron = 1'b0;
        #1;
        checkOutput("rst_valid", {127'd0, sdf__xx__valid}, 128'd0);
        checkOutput("rst_ptr_ready", {127'd0, sdf__xx__ptr_ready}, 128'd1);
        checkOutput("rst_read", {127'd0, sdf__sdm__read}, 128'd0);
        repeat (12) tick();
        checkOutput("rst_no_late_output", 128'(outCount), 128'd0);
        checkOutput("rst_still_idle", {127'd0, sdf__xx__ptr_ready}, 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
